// File: rtl/mem_test_sequencer_if.sv
// DRAM user-port bundle between the memory test sequencer (master) and the memory controller (slave).
interface mem_test_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 24
) ();

  logic [ADDR_WIDTH-1:0] o_dram_addr;
  logic                  o_dram_wr_en;
  logic                  o_dram_rd_en;
  logic [DATA_WIDTH-1:0] o_dram_wr_data;
  logic                  i_dram_ready;
  logic                  i_dram_rd_valid;
  logic [DATA_WIDTH-1:0] i_dram_rd_data;

  modport master (
    output o_dram_addr, o_dram_wr_en, o_dram_rd_en, o_dram_wr_data,
    input  i_dram_ready, i_dram_rd_valid, i_dram_rd_data
  );

  modport slave (
    input  o_dram_addr, o_dram_wr_en, o_dram_rd_en, o_dram_wr_data,
    output i_dram_ready, i_dram_rd_valid, i_dram_rd_data
  );

endinterface

// File: rtl/mem_test_sequencer.sv
// Write-then-read-back DRAM test sequencer with mismatch counting and first-error capture.
// Optional MEM_TEST_STOP_ON_ERROR_EN: the first mismatch halts read issue and drains outstanding responses.
module mem_test_sequencer #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned ADDR_WIDTH  = 24,
  parameter int unsigned NUM_WORDS   = 1024,
  parameter int unsigned ADDR_STRIDE = 8
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_calib_done,
  output logic                   o_gen_rst,
  output logic                   o_get_write_data,
  output logic                   o_get_validation_data,
  input  logic [DATA_WIDTH-1:0]  i_write_data,
  input  logic [DATA_WIDTH-1:0]  i_validation_data,
  mem_test_sequencer_if.master   dram,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  output logic [15:0]            o_error_count,
  output logic [ADDR_WIDTH-1:0]  o_first_error_addr
);

  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(ADDR_STRIDE);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_CALIB, S_WRITE, S_READ, S_DRAIN, S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_rsp_addr;
  logic [CNT_W-1:0]      r_wr_cnt;
  logic [CNT_W-1:0]      r_issue_cnt;
  logic [CNT_W-1:0]      r_resp_cnt;
  logic                  r_wr_en;
  logic                  r_rd_en;
  logic                  r_gen_rst;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [15:0]           r_err_cnt;
  logic [ADDR_WIDTH-1:0] r_first_err;

  logic w_wr_acc;
  logic w_rd_acc;
  logic w_rsp;
  logic w_mismatch;
  logic w_stop;

  assign w_wr_acc   = r_wr_en & dram.i_dram_ready;
  assign w_rd_acc   = r_rd_en & dram.i_dram_ready;
  assign w_rsp      = dram.i_dram_rd_valid & ((r_state == S_READ) | (r_state == S_DRAIN));
  assign w_mismatch = w_rsp & (dram.i_dram_rd_data != i_validation_data);

`ifdef MEM_TEST_STOP_ON_ERROR_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rsp_addr  <= '0;
      r_wr_cnt    <= '0;
      r_issue_cnt <= '0;
      r_resp_cnt  <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_gen_rst   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else begin
      r_gen_rst <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state     <= S_INIT;
            r_gen_rst   <= 1'b1;
            r_busy      <= 1'b1;
            r_addr      <= '0;
            r_rsp_addr  <= '0;
            r_wr_cnt    <= '0;
            r_issue_cnt <= '0;
            r_resp_cnt  <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
          end
        end
        S_INIT: r_state <= S_CALIB;
        S_CALIB: begin
          if (i_calib_done) begin
            r_state <= S_WRITE;
            r_wr_en <= 1'b1;
          end
        end
        S_WRITE: begin
          if (w_wr_acc) begin
            r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            if (r_wr_cnt == LAST_IDX) begin
              r_addr  <= '0;
              r_wr_en <= 1'b0;
              r_rd_en <= 1'b1;
              r_state <= S_READ;
            end else begin
              r_addr <= r_addr + STRIDE;
            end
          end
        end
        S_READ: begin
          if (w_rd_acc) begin
            r_addr      <= r_addr + STRIDE;
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            if (r_issue_cnt == LAST_IDX) begin
              r_rd_en <= 1'b0;
              r_state <= S_DRAIN;
            end
          end
          // An accept in the same cycle as the stopping mismatch is still counted above.
          if (w_stop) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_resp_cnt == r_issue_cnt) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Response checking runs alongside read issue and drain.
      if (w_rsp) begin
        r_resp_cnt <= r_resp_cnt + CNT_W'(1);
        r_rsp_addr <= r_rsp_addr + STRIDE;
        if (w_mismatch) begin
          r_error <= 1'b1;
          if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
          if (!r_error) r_first_err <= r_rsp_addr;
        end
      end
    end
  end

  assign o_gen_rst             = r_gen_rst | i_rst;
  assign o_get_write_data      = w_wr_acc;
  assign o_get_validation_data = w_rsp;
  assign dram.o_dram_addr      = r_addr;
  assign dram.o_dram_wr_en     = r_wr_en;
  assign dram.o_dram_rd_en     = r_rd_en;
  assign dram.o_dram_wr_data   = i_write_data;
  assign o_busy                = r_busy;
  assign o_done                = r_done;
  assign o_error               = r_error;
  assign o_error_count         = r_err_cnt;
  assign o_first_error_addr    = r_first_err;

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Directed self-checking bench for mem_test_sequencer with a 4-word echo memory and pattern generators.
module tb_mem_test_sequencer;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 24;
  localparam int unsigned NW = 4;
  localparam int unsigned ST = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, calib;
  logic          gen_rst, get_w, get_v;
  logic [DW-1:0] write_data, val_data;
  logic          busy, done, error;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_addr;

  mem_test_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_test_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW), .ADDR_STRIDE(ST)
  ) dut (
    .clk                   (clk),
    .i_rst                 (rst),
    .i_start               (start),
    .i_calib_done          (calib),
    .o_gen_rst             (gen_rst),
    .o_get_write_data      (get_w),
    .o_get_validation_data (get_v),
    .i_write_data          (write_data),
    .i_validation_data     (val_data),
    .dram                  (bus.master),
    .o_busy                (busy),
    .o_done                (done),
    .o_error               (error),
    .o_error_count         (err_cnt),
    .o_first_error_addr    (first_addr)
  );

  // Pattern generators: word k of a pass
  function automatic logic [DW-1:0] pat(input logic [7:0] k);
    return {4{24'hC0DE5A, k}};
  endfunction

  logic [7:0] wg = 8'd0, vg = 8'd0;
  always @(posedge clk) begin
    if (gen_rst) begin
      wg <= 8'd0;
      vg <= 8'd0;
    end else begin
      if (get_w) wg <= wg + 8'd1;
      if (get_v) vg <= vg + 8'd1;
    end
  end
  assign write_data = pat(wg);
  assign val_data   = pat(vg);

  // Echo memory with 2-cycle read latency and optional corruption
  logic          rdy_slow, corrupt;
  logic [AW-1:0] corrupt_addr;
  int unsigned   cyc = 0;
  logic [DW-1:0] mem [0:3];
  logic          p1_v = 1'b0, p2_v = 1'b0;
  logic [DW-1:0] p1_d = '0, p2_d = '0;

  assign bus.i_dram_ready    = rdy_slow ? ((cyc % 3) == 0) : 1'b1;
  assign bus.i_dram_rd_valid = p2_v;
  assign bus.i_dram_rd_data  = p2_d;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_dram_wr_en && bus.i_dram_ready) mem[bus.o_dram_addr[4:3]] <= bus.o_dram_wr_data;
    p1_v <= bus.o_dram_rd_en && bus.i_dram_ready;
    p1_d <= mem[bus.o_dram_addr[4:3]] ^
            ((corrupt && bus.o_dram_addr == corrupt_addr) ? DW'(1) : DW'(0));
    p2_v <= p1_v;
    p2_d <= p1_d;
  end

  // Monitor: accepted addresses, pulse counts, command-hold violations
  logic [AW-1:0] wlog[$];
  logic [AW-1:0] rlog[$];
  int            ngw = 0, ngv = 0, ngr = 0, hold_viol = 0;
  logic          pend_w = 1'b0, pend_r = 1'b0;
  logic [AW-1:0] pend_a = '0;

  always @(posedge clk) begin
    if (pend_w && !(bus.o_dram_wr_en && bus.o_dram_addr == pend_a)) hold_viol++;
    if (pend_r && !(bus.o_dram_rd_en && bus.o_dram_addr == pend_a)) hold_viol++;
    pend_w = bus.o_dram_wr_en && !bus.i_dram_ready && !rst;
    pend_r = bus.o_dram_rd_en && !bus.i_dram_ready && !rst;
    pend_a = bus.o_dram_addr;
    if (bus.o_dram_wr_en && bus.i_dram_ready) wlog.push_back(bus.o_dram_addr);
    if (bus.o_dram_rd_en && bus.i_dram_ready) rlog.push_back(bus.o_dram_addr);
    if (get_w) ngw++;
    if (get_v) ngv++;
    if (gen_rst && !rst) ngr++;
  end

  int errors = 0, checks = 0;
  int wb, rb, gwb, gvb, grb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    wb = wlog.size(); rb = rlog.size();
    gwb = ngw; gvb = ngv; grb = ngr;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (!done && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("done", 64'(done), 64'd1);
  endtask

  task automatic check_pass(input string tag, input int nwr, input int nrd);
    check({tag, "_nwr"}, 64'(wlog.size() - wb), 64'(nwr));
    check({tag, "_nrd"}, 64'(rlog.size() - rb), 64'(nrd));
    for (int i = 0; i < nwr && (wb + i) < wlog.size(); i++)
      check({tag, "_waddr"}, 64'(wlog[wb + i]), 64'(i * ST));
    for (int i = 0; i < nrd && (rb + i) < rlog.size(); i++)
      check({tag, "_raddr"}, 64'(rlog[rb + i]), 64'(i * ST));
  endtask

  initial begin
    int n;
    int busy_bad, cmd_bad;
    rst = 1'b1; start = 1'b0; calib = 1'b1;
    rdy_slow = 1'b0; corrupt = 1'b0; corrupt_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_gen_rst", 64'(gen_rst), 64'd1);
    check("rst_wr_en",   64'(bus.o_dram_wr_en), 64'd0);
    check("rst_rd_en",   64'(bus.o_dram_rd_en), 64'd0);
    check("rst_busy",    64'(busy), 64'd0);
    check("rst_done",    64'(done), 64'd0);
    check("rst_errcnt",  64'(err_cnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_gen_rst", 64'(gen_rst), 64'd0);

    // Clean pass
    mark();
    pulse_start();
    check("busy_started", 64'(busy), 64'd1);
    wait_done(200);
    check("t1_error",  64'(error), 64'd0);
    check("t1_errcnt", 64'(err_cnt), 64'd0);
    check("t1_busy",   64'(busy), 64'd0);
    check("t1_getw",   64'(ngw - gwb), 64'd4);
    check("t1_getv",   64'(ngv - gvb), 64'd4);
    check("t1_genrst", 64'(ngr - grb), 64'd1);
    check_pass("t1", 4, 4);

    // Corrupt word at address 16, then DONE must freeze
    corrupt = 1'b1; corrupt_addr = AW'(16);
    mark();
    pulse_start();
    wait_done(200);
    check("t2_error",  64'(error), 64'd1);
    check("t2_errcnt", 64'(err_cnt), 64'd1);
    check("t2_first",  64'(first_addr), 64'd16);
    repeat (5) @(negedge clk);
    check("t2_hold_done",   64'(done), 64'd1);
    check("t2_hold_errcnt", 64'(err_cnt), 64'd1);
    check("t2_hold_first",  64'(first_addr), 64'd16);

    // Ready 1-of-3 with a start pulse mid-write that must be ignored
    corrupt = 1'b0; rdy_slow = 1'b1;
    mark();
    pulse_start();
    n = 0;
    while ((wlog.size() - wb) < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    pulse_start();
    wait_done(400);
    check("t3_error", 64'(error), 64'd0);
    check("t3_getw",  64'(ngw - gwb), 64'd4);
    check("t3_getv",  64'(ngv - gvb), 64'd4);
    check("t3_hold",  64'(hold_viol), 64'd0);
    check_pass("t3", 4, 4);

    // Calibration held low for 50 cycles
    rdy_slow = 1'b0; calib = 1'b0;
    mark();
    pulse_start();
    busy_bad = 0; cmd_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!busy) busy_bad++;
      if (bus.o_dram_wr_en || bus.o_dram_rd_en) cmd_bad++;
    end
    check("t4_busy_calib", 64'(busy_bad), 64'd0);
    check("t4_cmd_calib",  64'(cmd_bad), 64'd0);
    calib = 1'b1;
    wait_done(200);
    check("t4_error", 64'(error), 64'd0);
    check_pass("t4", 4, 4);

    // Reset mid-READ with two reads outstanding, then a clean rerun
    mark();
    pulse_start();
    n = 0;
    while ((rlog.size() - rb) < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_outstanding", 64'(rlog.size() - rb), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    check("t5_wr_en",   64'(bus.o_dram_wr_en), 64'd0);
    check("t5_rd_en",   64'(bus.o_dram_rd_en), 64'd0);
    check("t5_busy",    64'(busy), 64'd0);
    check("t5_done",    64'(done), 64'd0);
    check("t5_error",   64'(error), 64'd0);
    check("t5_errcnt",  64'(err_cnt), 64'd0);
    check("t5_first",   64'(first_addr), 64'd0);
    check("t5_gen_rst", 64'(gen_rst), 64'd1);
    check("t5_getv",    64'(get_v), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    mark();
    pulse_start();
    wait_done(200);
    check("t5r_error",  64'(error), 64'd0);
    check("t5r_errcnt", 64'(err_cnt), 64'd0);
    check_pass("t5r", 4, 4);

`ifdef MEM_TEST_STOP_ON_ERROR_EN
    // Stop on first error: corrupt address 8 with slow ready
    corrupt = 1'b1; corrupt_addr = AW'(8); rdy_slow = 1'b1;
    mark();
    pulse_start();
    wait_done(400);
    check("t6_error",  64'(error), 64'd1);
    check("t6_errcnt", 64'(err_cnt), 64'd1);
    check("t6_first",  64'(first_addr), 64'd8);
    check("t6_getv",   64'(ngv - gvb), 64'd2);
    check_pass("t6", 4, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
